fb_write_arbiter: RTL and testbench

FB_WRITE_ARBITER -- requirements
Module: fb_write_arbiter

---
 rtl/fb_write_arbiter.sv | 90 +++++++++
 tb/tb_fb_write_arbiter.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/fb_write_arbiter.sv
// fb_write_arbiter: round-robin framebuffer write arbiter with a full-frame clear engine
module fb_write_arbiter #(
  parameter int H_MAX = 640,
  parameter int V_MAX = 480,
  parameter int BLANK_ONLY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        blank_n,
  input  logic        req0_valid,
  input  logic [18:0] req0_addr,
  input  logic [23:0] req0_data,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [18:0] req1_addr,
  input  logic [23:0] req1_data,
  output logic        req1_ready,
  input  logic        clr_start,
  input  logic [23:0] clr_color,
  output logic        clr_busy,
  output logic        clr_done,
  output logic        mem_we,
  output logic [18:0] mem_waddr,
  output logic [23:0] mem_wdata
);
  typedef enum logic [1:0] {IDLE, CLEAR, DONE} state_t;
  localparam logic [9:0] H_LAST = 10'(H_MAX - 1);
  localparam logic [8:0] V_LAST = 9'(V_MAX - 1);
  state_t state, state_nx;
  logic win, prio, grant, acc0, acc1, issue, in_idle, h_wrap, last;
  logic [9:0] h;
  logic [8:0] v;
  logic [23:0] color;
  assign win = (BLANK_ONLY == 0) | ~blank_n;
  assign grant = (req0_valid ^ req1_valid) ? req1_valid : prio;
  assign acc0 = req0_ready & req0_valid;
  assign acc1 = req1_ready & req1_valid;
  assign h_wrap = h == H_LAST;
  assign last = h_wrap & (v == V_LAST);
  // state register
  always_ff @(posedge clk)
    state <= !rst ? IDLE : state_nx;
  // next state: a clear runs until its final pixel write, then one DONE cycle
  always_comb
    state_nx = state == IDLE  ? (clr_start ? CLEAR : IDLE) :
               state == CLEAR ? (issue & last ? DONE : CLEAR) : IDLE;
  // outputs: requesters only see ready while idle inside the write window
  always_comb begin
    in_idle = state == IDLE;
    req0_ready = rst & in_idle & win & ~grant;
    req1_ready = rst & in_idle & win & grant;
    issue = (state == CLEAR) & win;
    clr_busy = !in_idle;
    clr_done = state == DONE;
  end
  // clear sweep position and latched fill colour
  always_ff @(posedge clk)
    if (!rst) begin
      h <= '0;
      v <= '0;
      color <= '0;
    end else if (in_idle & clr_start) begin
      h <= '0;
      v <= '0;
      color <= clr_color;
    end else if (issue) begin
      h <= h_wrap ? '0 : h + 10'd1;
      v <= h_wrap ? (v == V_LAST ? '0 : v + 9'd1) : v;
    end
  // round-robin pointer: favour the requester not served by the last accepted transfer
  always_ff @(posedge clk)
    if (!rst) prio <= 1'b0;
    else if (acc0 | acc1) prio <= acc0;
  // registered write port; address and data hold between strobes
  always_ff @(posedge clk)
    if (!rst) begin
      mem_we <= 1'b0;
      mem_waddr <= '0;
      mem_wdata <= '0;
    end else begin
      mem_we <= acc0 | acc1 | issue;
      if (acc0 | acc1) begin
        mem_waddr <= acc1 ? req1_addr : req0_addr;
        mem_wdata <= acc1 ? req1_data : req0_data;
      end else if (issue) begin
        mem_waddr <= {h, v};
        mem_wdata <= color;
      end
    end
endmodule

// File: tb/tb_fb_write_arbiter.sv
// tb_fb_write_arbiter: vector table, corner sequences and randomized model check
module tb_fb_write_arbiter;
  localparam int H = 4;
  localparam int V = 3;
  logic clk = 1'b0;
  logic rst, blank_n, req0_valid, req1_valid, req0_ready, req1_ready;
  logic [18:0] req0_addr, req1_addr, mem_waddr;
  logic [23:0] req0_data, req1_data, clr_color, mem_wdata;
  logic clr_start, clr_busy, clr_done, mem_we;
  int tests = 0;
  int fails = 0;
  int m_mode, m_n;
  bit m_prio, e_we;
  logic [18:0] e_addr;
  logic [23:0] e_data, m_color;
  logic s_r0, s_r1;

  fb_write_arbiter #(.H_MAX(H), .V_MAX(V), .BLANK_ONLY(1)) dut (
    .clk(clk), .rst(rst), .blank_n(blank_n),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
    .clr_start(clr_start), .clr_color(clr_color), .clr_busy(clr_busy), .clr_done(clr_done),
    .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    bit wn, gn, er0, er1, ac0, ac1;
    @(negedge clk);
    wn = !blank_n;
    gn = (req0_valid && !req1_valid) ? 1'b0 : (req1_valid && !req0_valid) ? 1'b1 : m_prio;
    er0 = rst && m_mode == 0 && wn && !gn;
    er1 = rst && m_mode == 0 && wn && gn;
    s_r0 = req0_ready;
    s_r1 = req1_ready;
    chk("ready0", req0_ready, er0);
    chk("ready1", req1_ready, er1);
    ac0 = er0 && req0_valid;
    ac1 = er1 && req1_valid;
    @(posedge clk);
    if (!rst) begin
      m_mode = 0; m_n = 0; m_prio = 0; e_we = 0; e_addr = 0; e_data = 0;
    end else begin
      e_we = 0;
      if (ac0 || ac1) begin
        e_we = 1;
        e_addr = ac1 ? req1_addr : req0_addr;
        e_data = ac1 ? req1_data : req0_data;
        m_prio = ac0;
      end
      if (m_mode == 0) begin
        if (clr_start) begin m_mode = 1; m_n = 0; m_color = clr_color; end
      end else if (m_mode == 1) begin
        if (wn) begin
          e_we = 1;
          e_addr = {10'(m_n % H), 9'(m_n / H)};
          e_data = m_color;
          m_n++;
          if (m_n == H * V) m_mode = 2;
        end
      end else m_mode = 0;
    end
    #1;
    chk("mem_we", mem_we, e_we);
    chk("mem_waddr", mem_waddr, e_addr);
    chk("mem_wdata", mem_wdata, e_data);
    chk("clr_busy", clr_busy, m_mode != 0);
    chk("clr_done", clr_done, m_mode == 2);
  endtask

  task automatic do_reset();
    rst = 0; clr_start = 0; req0_valid = 0; req1_valid = 0; blank_n = 1;
    tick();
    tick();
    rst = 1;
  endtask

  task automatic run_clear(input logic [23:0] col, input int per);
    int seen [H][V];
    int wr, dn, hh, vv;
    foreach (seen[i, j]) seen[i][j] = 0;
    blank_n = 0; clr_start = 1; clr_color = col;
    tick();
    clr_start = 0;
    wr = 0; dn = 0;
    for (int k = 0; k < 200 && dn == 0; k++) begin
      blank_n = per > 0 ? ((k / per) % 2 == 0) : 1'b0;
      tick();
      if (mem_we && mem_wdata == col) begin
        wr++;
        hh = int'(mem_waddr[18:9]);
        vv = int'(mem_waddr[8:0]);
        if (hh < H && vv < V) seen[hh][vv]++;
      end
      if (clr_done) begin
        dn++;
        chk("done_last_addr", mem_waddr, {10'(H - 1), 9'(V - 1)});
      end
    end
    chk("clear_done_seen", dn, 1);
    chk("clear_writes", wr, H * V);
    foreach (seen[i, j]) chk($sformatf("clear_addr_%0d_%0d", i, j), seen[i][j], 1);
    tick();
    chk("done_one_cycle", clr_done, 0);
  endtask

  typedef struct packed {
    logic bn, v0, v1;
    logic [18:0] a0;
    logic [23:0] d0;
    logic [18:0] a1;
    logic [23:0] d1;
    logic er0, er1, ewe;
    logic [18:0] eaddr;
    logic [23:0] edata;
  } vec_t;
  vec_t vt [9];

  initial begin
    int wr, bad;
    vt[0] = '{1'b0, 1'b1, 1'b1, 19'h2, 24'h111111, 19'h3, 24'h222222, 1'b1, 1'b0, 1'b1, 19'h2, 24'h111111};
    vt[1] = '{1'b0, 1'b1, 1'b1, 19'h2, 24'h111111, 19'h3, 24'h222222, 1'b0, 1'b1, 1'b1, 19'h3, 24'h222222};
    vt[2] = '{1'b0, 1'b1, 1'b1, 19'h2, 24'h111111, 19'h3, 24'h222222, 1'b1, 1'b0, 1'b1, 19'h2, 24'h111111};
    vt[3] = '{1'b0, 1'b1, 1'b1, 19'h2, 24'h111111, 19'h3, 24'h222222, 1'b0, 1'b1, 1'b1, 19'h3, 24'h222222};
    vt[4] = '{1'b1, 1'b1, 1'b1, 19'h2, 24'h111111, 19'h3, 24'h222222, 1'b0, 1'b0, 1'b0, 19'h3, 24'h222222};
    vt[5] = '{1'b0, 1'b1, 1'b0, 19'h1, 24'hFF0000, 19'h0, 24'h000000, 1'b1, 1'b0, 1'b1, 19'h1, 24'hFF0000};
    vt[6] = '{1'b0, 1'b0, 1'b1, 19'h0, 24'h000000, 19'h40005, 24'h0000FF, 1'b0, 1'b1, 1'b1, 19'h40005, 24'h0000FF};
    vt[7] = '{1'b0, 1'b0, 1'b0, 19'h0, 24'h000000, 19'h0, 24'h000000, 1'b1, 1'b0, 1'b0, 19'h40005, 24'h0000FF};
    vt[8] = '{1'b1, 1'b0, 1'b1, 19'h0, 24'h000000, 19'h7, 24'h000007, 1'b0, 1'b0, 1'b0, 19'h40005, 24'h0000FF};
    rst = 0; blank_n = 1; req0_valid = 0; req1_valid = 0; req0_addr = 0; req1_addr = 0;
    req0_data = 0; req1_data = 0; clr_start = 0; clr_color = 0;
    do_reset();
    chk("reset_we", mem_we, 0);
    chk("reset_addr", mem_waddr, 0);
    chk("reset_busy", clr_busy, 0);
    for (int i = 0; i < 9; i++) begin
      blank_n = vt[i].bn; req0_valid = vt[i].v0; req1_valid = vt[i].v1;
      req0_addr = vt[i].a0; req0_data = vt[i].d0; req1_addr = vt[i].a1; req1_data = vt[i].d1;
      tick();
      chk($sformatf("vec%0d_ready0", i), s_r0, vt[i].er0);
      chk($sformatf("vec%0d_ready1", i), s_r1, vt[i].er1);
      chk($sformatf("vec%0d_we", i), mem_we, vt[i].ewe);
      chk($sformatf("vec%0d_addr", i), mem_waddr, vt[i].eaddr);
      chk($sformatf("vec%0d_data", i), mem_wdata, vt[i].edata);
    end
    req0_valid = 0; req1_valid = 0;
    do_reset();
    run_clear(24'h00FF00, 0);
    run_clear(24'h0F0F0F, 5);
    do_reset();
    blank_n = 0; clr_color = 24'h0000AA; clr_start = 1;
    tick();
    clr_start = 0; wr = 0;
    for (int k = 0; k < 40 && wr < 5; k++) begin
      tick();
      if (mem_we) wr++;
    end
    chk("mid_writes", wr, 5);
    rst = 0;
    tick();
    chk("abort_ready0", s_r0, 0);
    chk("abort_we", mem_we, 0);
    chk("abort_addr", mem_waddr, 0);
    chk("abort_data", mem_wdata, 0);
    chk("abort_busy", clr_busy, 0);
    chk("abort_done", clr_done, 0);
    rst = 1;
    tick();
    chk("abort_no_done", clr_done, 0);
    clr_color = 24'h0000BB; clr_start = 1;
    tick();
    clr_start = 0;
    tick();
    chk("restart_we", mem_we, 1);
    chk("restart_addr", mem_waddr, 0);
    chk("restart_data", mem_wdata, 24'h0000BB);
    for (int k = 0; k < 40 && !clr_done; k++) tick();
    chk("restart_done", clr_done, 1);
    tick();
    do_reset();
    blank_n = 0; req1_valid = 1; req1_addr = 19'h12345; req1_data = 24'hABCDEF;
    clr_start = 1; clr_color = 24'h00FF00;
    tick();
    chk("race_ready1", s_r1, 1);
    chk("race_req_we", mem_we, 1);
    chk("race_req_addr", mem_waddr, 19'h12345);
    chk("race_req_data", mem_wdata, 24'hABCDEF);
    chk("race_busy", clr_busy, 1);
    clr_start = 0; req0_valid = 1; wr = 0; bad = 0;
    for (int k = 0; k < 40 && !clr_done; k++) begin
      clr_start = k == 2;
      clr_color = k == 2 ? 24'h123456 : 24'h00FF00;
      tick();
      if (s_r0 || s_r1) bad++;
      if (mem_we && mem_wdata == 24'h00FF00) wr++;
      else if (mem_we) bad++;
    end
    chk("race_clear_writes", wr, H * V);
    chk("race_bad", bad, 0);
    clr_start = 0; req0_valid = 0; req1_valid = 0;
    tick();
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom % 150) != 0;
      blank_n = $urandom % 2;
      req0_valid = $urandom % 2; req1_valid = $urandom % 2;
      req0_addr = 19'($urandom); req1_addr = 19'($urandom);
      req0_data = 24'($urandom); req1_data = 24'($urandom);
      clr_start = ($urandom % 30) == 0;
      clr_color = 24'($urandom);
      tick();
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
